// File: rtl/adder4_seq_acc.sv
// adder4_seq_acc: 8-bit burst accumulator built around an external 4-bit adder.
// Each operand is added in two passes through the adder, low nibble first and
// then high nibble. The carry between the two passes is held in a register.
// The total and a sticky overflow flag are returned over a valid/ready handshake.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | quiescent, all outputs 0, waits for start
// WAIT  | op_ready=1, waits for an operand
// LO    | low-nibble pass: acc[3:0] + opreg[3:0]
// HI    | high-nibble pass: acc[7:4] + opreg[7:4] + carry
// DONE  | result presented until res_ready
module adder4_seq_acc #(
  parameter int NUM_OPS = 4  // operands per burst, 2..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op_valid,
  input  logic [7:0] op_data,
  output logic       op_ready,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_ovf,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(NUM_OPS - 1);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] opreg_q, opreg_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic [3:0] cnt_q, cnt_d;

  // Next-state and datapath update; the adder result is only consumed in LO/HI.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opreg_d = opreg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 8'h00;
          ovf_d   = 1'b0;
          cnt_d   = 4'd0;
          carry_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (op_valid) begin
          opreg_d = op_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        acc_d[3:0] = add_sum;
        carry_d    = add_cout;
        state_d    = S_HI;
      end
      S_HI: begin
        acc_d[7:4] = add_sum;
        // Only the high-nibble carry-out is a true 8-bit overflow.
        ovf_d      = ovf_q | add_cout;
        cnt_d      = cnt_q + 4'd1;
        state_d    = (cnt_q == LAST_CNT) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      opreg_q <= 8'h00;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opreg_q <= opreg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from registers only, so there is no input-to-output path.
  always_comb begin
    op_ready  = (state_q == S_WAIT);
    busy      = (state_q != S_IDLE);
    res_valid = (state_q == S_DONE);
    res_data  = (state_q == S_DONE) ? acc_q : 8'h00;
    res_ovf   = (state_q == S_DONE) ? ovf_q : 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    if (state_q == S_LO) begin
      add_a = acc_q[3:0];
      add_b = opreg_q[3:0];
    end else if (state_q == S_HI) begin
      add_a   = acc_q[7:4];
      add_b   = opreg_q[7:4];
      add_cin = carry_q;
    end
  end

endmodule

// File: tb/tb_adder4_seq_acc.sv
// Testbench for adder4_seq_acc: behavioural 4-bit adder on the add_* ports,
// running-sum reference model, directed bursts with literal expectations.
module tb_adder4_seq_acc;

  localparam int NUM_OPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op_valid = 1'b0;
  logic [7:0] op_data = 8'h00;
  logic       op_ready;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       res_valid, res_ovf, busy;
  logic [7:0] res_data;
  logic       res_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  adder4_seq_acc #(.NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_data(op_data),
    .op_ready(op_ready), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .res_valid(res_valid),
    .res_data(res_data), .res_ovf(res_ovf), .res_ready(res_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: running 8-bit sum of accepted operands, overflow when a
  // 9-bit add of running sum and operand carries out.
  logic [7:0] m_acc = 8'h00;
  logic       m_ovf = 1'b0;
  int         m_n = 0;
  logic [8:0] m_t;
  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      m_acc <= 8'h00;
      m_ovf <= 1'b0;
      m_n   <= 0;
    end else if (op_valid && op_ready) begin
      m_t = {1'b0, m_acc} + {1'b0, op_data};
      m_acc <= m_t[7:0];
      m_ovf <= m_ovf | m_t[8];
      m_n   <= m_n + 1;
    end
  end

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!busy)
      chk("idle_outputs_zero", 32'({op_ready, res_valid, res_data, res_ovf, add_a, add_b, add_cin}), 32'd0);
    if (res_valid) begin
      chk("res_data_vs_model", 32'(res_data), 32'(m_acc));
      chk("res_ovf_vs_model", 32'(res_ovf), 32'(m_ovf));
      chk("res_opcount", 32'(m_n), 32'(NUM_OPS));
    end
    if (op_ready)
      chk("ready_only_in_wait", 32'({busy, res_valid}), 32'b10);
  end

  // Called at a negedge: pulse start for one cycle, returns at the next negedge.
  task automatic do_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("op_ready_after_start", 32'(op_ready), 32'd1);
  endtask

  // Called at a negedge: wait for op_ready, idle for gap cycles, then present
  // the operand for one cycle. Returns at the negedge of the LO cycle.
  task automatic send_op(input logic [7:0] d, input int gap);
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      if (op_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("op_ready_timeout", 32'd0, 32'd1);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("op_ready_held_in_gap", 32'(op_ready), 32'd1);
    end
    op_valid = 1'b1;
    op_data  = d;
    @(negedge clk);
    op_valid = 1'b0;
    op_data  = 8'hEE;
  endtask

  // Wait for the result, check literals, optionally stall with start pulses,
  // then complete the handshake with start also high (must not restart).
  task automatic get_result(input logic [7:0] exp_d, input logic exp_o, input int hold,
                            input int c0, input int exp_lat);
    bit got = 0;
    logic [7:0] d0;
    logic o0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("res_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_lat > 0) chk("res_latency", 32'(cyc - c0), 32'(exp_lat));
    chk("res_data_literal", 32'(res_data), 32'(exp_d));
    chk("res_ovf_literal", 32'(res_ovf), 32'(exp_o));
    d0 = res_data;
    o0 = res_ovf;
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      @(negedge clk);
      chk("stall_valid", 32'({res_valid, busy}), 32'b11);
      chk("stall_data", 32'({res_data, res_ovf}), 32'({d0, o0}));
    end
    start = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    chk("idle_after_handshake", 32'({busy, res_valid}), 32'd0);
  endtask

  initial begin
    int c0;
    // Reset with start held high: must stay idle.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Basic sum with latency.
    do_start(c0);
    send_op(8'h01, 0);
    send_op(8'h02, 0);
    send_op(8'h03, 0);
    send_op(8'h04, 0);
    get_result(8'h0A, 1'b0, 0, c0, 3 * NUM_OPS + 1);

    // Nibble carry between LO and HI of the second operand.
    @(negedge clk);
    do_start(c0);
    send_op(8'h0F, 0);
    send_op(8'h01, 0);
    chk("lo_ports", 32'({add_a, add_b, add_cin, add_cout}), 32'({4'hF, 4'h1, 1'b0, 1'b1}));
    @(negedge clk);
    chk("hi_ports", 32'({add_a, add_b, add_cin}), 32'({4'h0, 4'h0, 1'b1}));
    send_op(8'h00, 0);
    send_op(8'h00, 0);
    get_result(8'h10, 1'b0, 0, c0, 3 * NUM_OPS + 1);

    // Sticky overflow.
    @(negedge clk);
    do_start(c0);
    send_op(8'hFF, 0);
    send_op(8'h01, 0);
    send_op(8'h80, 0);
    send_op(8'h80, 0);
    get_result(8'h00, 1'b1, 0, c0, 3 * NUM_OPS + 1);

    // Gaps on op_valid and stall on res_ready with start pulses.
    @(negedge clk);
    do_start(c0);
    send_op(8'h10, 2);
    send_op(8'h20, 2);
    send_op(8'h30, 2);
    send_op(8'h40, 2);
    get_result(8'hA0, 1'b0, 5, c0, 0);

    // Reset during HI of the second operand, then a clean burst.
    @(negedge clk);
    do_start(c0);
    send_op(8'h77, 0);
    send_op(8'h99, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", 32'({busy, op_ready, res_valid, res_data, res_ovf, add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_abort_busy", 32'({busy, res_valid}), 32'd0);
    do_start(c0);
    send_op(8'h05, 0);
    send_op(8'h05, 0);
    send_op(8'h05, 0);
    send_op(8'h05, 0);
    get_result(8'h14, 1'b0, 0, c0, 3 * NUM_OPS + 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
